// File: rtl/mac_pkg.sv
// Shared constants and the requantisation rule for the 4-bit MAC datapath.
// The MAC producer, this buffer and the bench's reference model all use it.
package mac_pkg;

    localparam int OFM_W = 10;
    localparam int IFM_W = 4;

    localparam logic [OFM_W-1:0] IFM_MAX = OFM_W'((1 << IFM_W) - 1);

    // Unsigned right shift, then clamp to the largest IFM code (no rounding).
    function automatic logic [IFM_W-1:0] requant(input logic [OFM_W-1:0] ofm,
                                                 input int unsigned      shift);
        logic [OFM_W-1:0] q;
        q = ofm >> shift;
        if (q > IFM_MAX) begin
            return IFM_MAX[IFM_W-1:0];
        end
        return q[IFM_W-1:0];
    endfunction

endpackage

// File: rtl/ofm_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word lives in a register,
// so rdata is already valid in the same cycle that out_valid rises.
module ofm_sync_fifo
    import mac_pkg::*;
#(
    parameter int W     = IFM_W,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic             out_valid,
    output logic [W-1:0]     rdata,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_nxt;
    logic [W-1:0]     head_q;
    logic [W-1:0]     head_nxt;

    assign rd_nxt = rd_ptr + PTR_W'(pop);

    always_comb begin
        level_nxt = level_q;
        case ({push, pop})
            2'b10:   level_nxt = level_q + LVL_W'(1);
            2'b01:   level_nxt = level_q - LVL_W'(1);
            default: level_nxt = level_q;
        endcase
    end

    // The incoming word bypasses storage when it lands exactly at the next head slot.
    always_comb begin
        head_nxt = mem[rd_nxt];
        if (level_nxt == '0) begin
            head_nxt = '0;
        end else if (push && (wr_ptr == rd_nxt)) begin
            head_nxt = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_nxt;
            level_q <= level_nxt;
            head_q  <= head_nxt;
        end
    end

    assign out_valid = (level_q != '0);
    assign rdata     = head_q;
    assign level     = level_q;

endmodule

// File: rtl/ofm_requant_fifo.sv
// Requantises each MAC accumulator result to an IFM word and buffers it for the
// next layer. The MAC cannot be stalled, so a full buffer drops and flags results.
module ofm_requant_fifo
    import mac_pkg::*;
#(
    parameter int IN_W  = OFM_W,
    parameter int OUT_W = IFM_W,
    parameter int SHIFT = 2,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_OFM,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_IFM,
    output logic [LVL_W-1:0] level,
    output logic             ovf
);

    logic [OUT_W-1:0] word_p0;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic             ovf_q;

    assign word_p0 = requant(in_OFM, SHIFT);

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign full = (level == LVL_W'(DEPTH));
    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    ofm_sync_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .wdata     (word_p0),
        .out_valid (out_valid),
        .rdata     (out_IFM),
        .level     (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_ofm_requant_fifo.sv
// Directed bench for ofm_requant_fifo: per-cycle vector table with hand-computed
// outputs, plus explicit sequences for asynchronous reset behaviour.
module tb_ofm_requant_fifo;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [9:0] in_OFM;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_IFM;
    logic [2:0] level;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       v;
        logic [9:0] ofm;
        logic       rdy;
        logic       e_valid;
        logic [3:0] e_ifm;
        logic [2:0] e_level;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    ofm_requant_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_OFM    (in_OFM),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_IFM   (out_IFM),
        .level     (level),
        .ovf       (ovf)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ev, input int ei, input int el, input int eo);
        chk({tag, ".out_valid"}, int'(out_valid), ev);
        chk({tag, ".out_IFM"},   int'(out_IFM),   ei);
        chk({tag, ".level"},     int'(level),     el);
        chk({tag, ".ovf"},       int'(ovf),       eo);
    endtask

    task automatic add(input logic v, input int ofm, input logic rdy,
                       input logic ev, input int ei, input int el, input logic eo);
        vec_t r;
        r.v = v; r.ofm = 10'(ofm); r.rdy = rdy;
        r.e_valid = ev; r.e_ifm = 4'(ei); r.e_level = 3'(el); r.e_ovf = eo;
        vecs.push_back(r);
    endtask

    // Each row: inputs held for one cycle, outputs checked just after that edge.
    task automatic run_vecs(input string phase);
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid  = vecs[i].v;
            in_OFM    = vecs[i].ofm;
            out_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk_all($sformatf("%s[%0d]", phase, i), int'(vecs[i].e_valid),
                    int'(vecs[i].e_ifm), int'(vecs[i].e_level), int'(vecs[i].e_ovf));
        end
        vecs.delete();
        @(negedge clk);
        in_valid  = 1'b0;
        in_OFM    = '0;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_OFM    = '0;
        out_ready = 1'b0;
        #5;
        rst_n = 1'b1;
        #1;
        chk_all("reset", 0, 0, 0, 0);

        //   v  ofm  rdy  valid ifm lvl ovf
        add(1,    0, 1,   1,  0, 1, 0);
        add(1,    2, 1,   1,  0, 1, 0);
        add(1,    8, 1,   1,  2, 1, 0);
        add(1,   20, 1,   1,  5, 1, 0);
        add(0,    0, 1,   0,  0, 0, 0);
        add(0,    0, 1,   0,  0, 0, 0);
        run_vecs("mac");

        add(1,   60, 1,   1, 15, 1, 0);
        add(1,   64, 1,   1, 15, 1, 0);
        add(1, 1023, 1,   1, 15, 1, 0);
        add(1,   59, 1,   1, 14, 1, 0);
        add(0,    0, 1,   0,  0, 0, 0);
        run_vecs("sat");

        add(1,    4, 0,   1,  1, 1, 0);
        add(1,    8, 0,   1,  1, 2, 0);
        add(1,   12, 0,   1,  1, 3, 0);
        add(1,   16, 0,   1,  1, 4, 0);
        add(1,   20, 0,   1,  1, 4, 1);
        add(0,    0, 0,   1,  1, 4, 1);
        add(0,    0, 1,   1,  2, 3, 1);
        add(0,    0, 1,   1,  3, 2, 1);
        add(0,    0, 1,   1,  4, 1, 1);
        add(0,    0, 1,   0,  0, 0, 1);
        run_vecs("ovf");

        pulse_reset();
        #1;
        chk_all("ovf_clear", 0, 0, 0, 0);

        add(1,    4, 0,   1,  1, 1, 0);
        add(1,    8, 0,   1,  1, 2, 0);
        add(1,   12, 0,   1,  1, 3, 0);
        add(1,   16, 0,   1,  1, 4, 0);
        add(1,   40, 1,   1,  2, 4, 0);
        add(0,    0, 1,   1,  3, 3, 0);
        add(0,    0, 1,   1,  4, 2, 0);
        add(0,    0, 1,   1, 10, 1, 0);
        add(0,    0, 1,   0,  0, 0, 0);
        run_vecs("fullpp");

        // Build a backlog, then pull reset low in the middle of a clock phase.
        add(1,   28, 0,   1,  7, 1, 0);
        add(1,   32, 0,   1,  7, 2, 0);
        add(1,   36, 0,   1,  7, 3, 0);
        run_vecs("pre_rst");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("rst_hold", 0, 0, 0, 0);

        add(1,   40, 0,   1, 10, 1, 0);
        add(0,    0, 1,   0,  0, 0, 0);
        run_vecs("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
